// File: rtl/blake2b_msg_packer_pkg.sv
// Shared constants and helpers for the BLAKE2b message packer.
package blake2b_msg_packer_pkg;

    localparam int unsigned BLAKE2B_BLK_BYTS = 128;
    localparam int unsigned BLK_BITS         = BLAKE2B_BLK_BYTS * 8;
    // Wide enough to hold a byte pointer value of 128 (block full).
    localparam int unsigned PTR_W            = 8;

    // Number of valid bytes carried by a beat: i_mod on eop, 0 meaning full width.
    function automatic logic [PTR_W-1:0] beat_byts(
        input int unsigned      in_byts,
        input logic             eop,
        input logic [PTR_W-1:0] mod
    );
        if (eop && (mod != '0)) begin
            return mod;
        end
        return PTR_W'(in_byts);
    endfunction

endpackage

// File: rtl/blake2b_msg_packer_blk_slot.sv
// One 128-byte block buffer: byte-enable write port, metadata and a valid flag.
module blake2b_msg_packer_blk_slot
    import blake2b_msg_packer_pkg::*;
#(
    parameter int unsigned META_W = 42
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_clr,
    input  logic                        i_wr,
    input  logic [BLAKE2B_BLK_BYTS-1:0] i_be,
    input  logic [BLK_BITS-1:0]         i_dat,
    input  logic                        i_set,
    input  logic [META_W-1:0]           i_meta,
    input  logic                        i_take,
    output logic [BLK_BITS-1:0]         o_dat,
    output logic [META_W-1:0]           o_meta,
    output logic                        o_val
);

    logic [BLK_BITS-1:0] dat_q, dat_d;
    logic [META_W-1:0]   meta_q, meta_d;
    logic                val_q, val_d;

    // Clear-then-write so a block start zero-fills every byte the message never reaches.
    always_comb begin
        dat_d  = dat_q;
        meta_d = meta_q;
        val_d  = val_q;
        if (i_clr) begin
            dat_d = '0;
        end
        if (i_wr) begin
            for (int b = 0; b < int'(BLAKE2B_BLK_BYTS); b++) begin
                if (i_be[b]) begin
                    dat_d[8*b +: 8] = i_dat[8*b +: 8];
                end
            end
        end
        if (i_set) begin
            meta_d = i_meta;
            val_d  = 1'b1;
        end else if (i_take) begin
            val_d  = 1'b0;
        end
    end

    // Slot state register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            dat_q  <= '0;
            meta_q <= '0;
            val_q  <= 1'b0;
        end else begin
            dat_q  <= dat_d;
            meta_q <= meta_d;
            val_q  <= val_d;
        end
    end

    assign o_dat  = dat_q;
    assign o_meta = meta_q;
    assign o_val  = val_q;

endmodule

// File: rtl/blake2b_msg_packer.sv
// Packs a variable-length beat stream into 128-byte BLAKE2b blocks with t/first/last/tag metadata.
module blake2b_msg_packer
    import blake2b_msg_packer_pkg::*;
#(
    parameter int unsigned IN_BYTS  = 8,
    parameter int unsigned CNT_BITS = 32,
    parameter int unsigned CTL_BITS = 8
) (
    input  logic                                             i_clk,
    input  logic                                             i_rst_n,
    input  logic [IN_BYTS*8-1:0]                             i_dat,
    input  logic                                             i_val,
    input  logic                                             i_sop,
    input  logic                                             i_eop,
    input  logic [((IN_BYTS > 1) ? $clog2(IN_BYTS) : 1)-1:0] i_mod,
    input  logic [CTL_BITS-1:0]                              i_ctl,
    output logic                                             o_rdy,
    output logic [BLK_BITS-1:0]                              o_blk,
    output logic [CNT_BITS-1:0]                              o_blk_t,
    output logic                                             o_blk_first,
    output logic                                             o_blk_last,
    output logic [CTL_BITS-1:0]                              o_blk_ctl,
    output logic                                             o_blk_val,
    input  logic                                             i_blk_rdy,
    output logic                                             o_err
);

    localparam int unsigned CS_W = CNT_BITS + 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_FILL = 1'b1;

    typedef struct packed {
        logic [CNT_BITS-1:0] t;
        logic                first;
        logic                last;
        logic [CTL_BITS-1:0] ctl;
    } blk_meta_t;

    localparam int unsigned META_W = $bits(blk_meta_t);

    logic [0:0]          state_q, state_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic                sat_q, sat_d;
    logic                first_q, first_d;
    logic [CTL_BITS-1:0] ctl_q, ctl_d;
    logic                wr_sel_q, wr_sel_d;
    logic                rd_sel_q, rd_sel_d;
    logic                rdy_q, rdy_d;
    logic                err_q, err_d;

    logic                accept, consume, start, beat_ok, proto_err;
    logic [PTR_W-1:0]    base_ptr, nbytes, ptr_end;
    logic [CNT_BITS-1:0] base_cnt, t_new;
    logic                base_sat, base_first, ovf, blk_done;
    logic [CTL_BITS-1:0] base_ctl;
    logic [CS_W-1:0]     cnt_sum;
    logic [IN_BYTS-1:0]  lane_en;

    logic [1:0]                  slot_wr, slot_clr, slot_set, slot_take, slot_val, val_next;
    logic [BLAKE2B_BLK_BYTS-1:0] wr_be;
    logic [BLK_BITS-1:0]         wr_dat;
    blk_meta_t                   wr_meta;
    logic [BLK_BITS-1:0]         slot_dat [2];
    blk_meta_t                   slot_meta [2];
    blk_meta_t                   rd_meta;

    // Fill FSM next state, beat placement, block completion and ping-pong bookkeeping.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        sat_d     = sat_q;
        first_d   = first_q;
        ctl_d     = ctl_q;
        wr_sel_d  = wr_sel_q;
        rd_sel_d  = rd_sel_q;
        err_d     = 1'b0;
        slot_wr   = '0;
        slot_clr  = '0;
        slot_set  = '0;
        slot_take = '0;

        accept    = i_val & rdy_q;
        consume   = slot_val[rd_sel_q] & i_blk_rdy;
        start     = accept & i_sop;
        beat_ok   = accept & (i_sop | (state_q == ST_FILL));
        proto_err = accept & (i_sop ? (state_q == ST_FILL) : (state_q == ST_IDLE));

        // A sop beat restarts everything, discarding any partial block of an aborted message.
        base_ptr   = start ? '0 : ptr_q;
        base_cnt   = start ? '0 : cnt_q;
        base_sat   = start ? 1'b0 : sat_q;
        base_first = start ? 1'b1 : first_q;
        base_ctl   = start ? i_ctl : ctl_q;

        nbytes   = beat_byts(IN_BYTS, i_eop, PTR_W'(i_mod));
        cnt_sum  = CS_W'(base_cnt) + CS_W'(nbytes);
        ovf      = cnt_sum[CNT_BITS];
        t_new    = (base_sat | ovf) ? '1 : cnt_sum[CNT_BITS-1:0];
        ptr_end  = base_ptr + nbytes;
        blk_done = i_eop | (ptr_end == PTR_W'(BLAKE2B_BLK_BYTS));

        for (int j = 0; j < int'(IN_BYTS); j++) begin
            lane_en[j] = (PTR_W'(j) < nbytes);
        end
        wr_be  = BLAKE2B_BLK_BYTS'(lane_en) << base_ptr;
        wr_dat = BLK_BITS'(i_dat) << {base_ptr, 3'b000};

        wr_meta       = '0;
        wr_meta.t     = t_new;
        wr_meta.first = base_first;
        wr_meta.last  = i_eop;
        wr_meta.ctl   = base_ctl;

        if (proto_err) begin
            err_d = 1'b1;
        end

        if (beat_ok) begin
            slot_wr[wr_sel_q]  = 1'b1;
            slot_clr[wr_sel_q] = (base_ptr == '0);
            cnt_d   = t_new;
            sat_d   = base_sat | ovf;
            first_d = base_first;
            ctl_d   = base_ctl;
            ptr_d   = ptr_end;
            state_d = i_eop ? ST_IDLE : ST_FILL;
            if (ovf & ~base_sat) begin
                err_d = 1'b1;
            end
            if (blk_done) begin
                slot_set[wr_sel_q] = 1'b1;
                first_d  = 1'b0;
                ptr_d    = '0;
                wr_sel_d = ~wr_sel_q;
            end
        end

        if (consume) begin
            slot_take[rd_sel_q] = 1'b1;
            rd_sel_d = ~rd_sel_q;
        end

        val_next = (slot_val & ~slot_take) | slot_set;
        rdy_d    = ~(&val_next);
    end

    // Control register file.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            cnt_q    <= '0;
            sat_q    <= 1'b0;
            first_q  <= 1'b0;
            ctl_q    <= '0;
            wr_sel_q <= 1'b0;
            rd_sel_q <= 1'b0;
            rdy_q    <= 1'b1;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            sat_q    <= sat_d;
            first_q  <= first_d;
            ctl_q    <= ctl_d;
            wr_sel_q <= wr_sel_d;
            rd_sel_q <= rd_sel_d;
            rdy_q    <= rdy_d;
            err_q    <= err_d;
        end
    end

    // Ping-pong block buffers.
    for (genvar g = 0; g < 2; g++) begin : g_slot
        blake2b_msg_packer_blk_slot #(
            .META_W (META_W)
        ) u_slot (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_clr   (slot_clr[g]),
            .i_wr    (slot_wr[g]),
            .i_be    (wr_be),
            .i_dat   (wr_dat),
            .i_set   (slot_set[g]),
            .i_meta  (wr_meta),
            .i_take  (slot_take[g]),
            .o_dat   (slot_dat[g]),
            .o_meta  (slot_meta[g]),
            .o_val   (slot_val[g])
        );
    end

    assign rd_meta     = slot_meta[rd_sel_q];
    assign o_blk       = slot_dat[rd_sel_q];
    assign o_blk_t     = rd_meta.t;
    assign o_blk_first = rd_meta.first;
    assign o_blk_last  = rd_meta.last;
    assign o_blk_ctl   = rd_meta.ctl;
    assign o_blk_val   = slot_val[rd_sel_q];
    assign o_rdy       = rdy_q;
    assign o_err       = err_q;

endmodule
